// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer
// Drives the read/twiddle/write-back addressing for an in-place radix-2
// decimation-in-time FFT. The samples are already stored bit-reversed in a
// dual-port RAM. One butterfly is issued per RUN cycle. Its write-back is
// the read request delayed by one cycle, which matches the 1-cycle RAM/ROM
// latency in front of a combinational butterfly. A single DRAIN bubble
// between stages means stage s+1 never reads a word in the same cycle
// that stage s writes it.
module fft_stage_sequencer #(
    parameter int N_LOG2 = 3,
    parameter int ADDR_W = N_LOG2,
    parameter int TW_W   = (N_LOG2 > 1) ? (N_LOG2 - 1) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic [N_LOG2-1:0] o_stage,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr_a,
    output logic [ADDR_W-1:0] o_rd_addr_b,
    output logic [TW_W-1:0]   o_tw_addr,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr_a,
    output logic [ADDR_W-1:0] o_wr_addr_b
);

    // k counts the butterflies within a stage (0 .. N/2-1).
    localparam int K_W = (N_LOG2 > 1) ? (N_LOG2 - 1) : 1;
    localparam int S_W = N_LOG2;

    localparam logic [K_W-1:0] K_LAST = K_W'((32'sd1 <<< (N_LOG2 - 1)) - 32'sd1);
    localparam logic [S_W-1:0] S_LAST = S_W'(N_LOG2 - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [S_W-1:0] s_r;
    logic [S_W-1:0] s_s;
    logic [K_W-1:0] k_r;
    logic [K_W-1:0] k_s;

    logic              busy_s;
    logic              done_s;
    logic [S_W-1:0]    stage_s;
    logic              rd_en_s;
    logic [ADDR_W-1:0] rd_addr_a_s;
    logic [ADDR_W-1:0] rd_addr_b_s;
    logic [TW_W-1:0]   tw_addr_s;

    // Top input of butterfly k in stage s: grp*2*half + pos.
    function automatic logic [ADDR_W-1:0] addr_a_f(input logic [S_W-1:0] s,
                                                   input logic [K_W-1:0] k);
        logic [ADDR_W-1:0] kx;
        logic [ADDR_W-1:0] half;
        logic [ADDR_W-1:0] pos;
        logic [ADDR_W-1:0] grp;
        kx       = ADDR_W'(k);
        half     = ADDR_W'(1'b1) << s;
        pos      = kx & (half - ADDR_W'(1'b1));
        grp      = kx >> s;
        addr_a_f = (grp << (s + S_W'(1'b1))) | pos;
    endfunction

    // Bottom input sits one half-span above the top input.
    function automatic logic [ADDR_W-1:0] addr_b_f(input logic [S_W-1:0] s,
                                                   input logic [K_W-1:0] k);
        addr_b_f = addr_a_f(s, k) + (ADDR_W'(1'b1) << s);
    endfunction

    // Twiddle index W_N^(pos * N / (2*half)) = pos << (N_LOG2-1-s).
    function automatic logic [TW_W-1:0] tw_addr_f(input logic [S_W-1:0] s,
                                                  input logic [K_W-1:0] k);
        logic [ADDR_W-1:0] pos;
        logic [S_W-1:0]    sh;
        pos       = ADDR_W'(k) & ((ADDR_W'(1'b1) << s) - ADDR_W'(1'b1));
        sh        = S_LAST - s;
        tw_addr_f = TW_W'(pos << sh);
    endfunction

    // State and counter register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            s_r     <= '0;
            k_r     <= '0;
        end else begin
            state_r <= state_s;
            s_r     <= s_s;
            k_r     <= k_s;
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        state_s = state_r;
        s_s     = s_r;
        k_s     = k_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_s = ST_RUN;
                    s_s     = '0;
                    k_s     = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (k_r == K_LAST) begin
                    state_s = ST_DRAIN;
                end else begin
                    k_s = k_r + K_W'(1'b1);
                end
            end
            ST_DRAIN: begin
                if (s_r < S_LAST) begin
                    state_s = ST_RUN;
                    s_s     = s_r + S_W'(1'b1);
                    k_s     = '0;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                s_s     = '0;
                k_s     = '0;
            end
            default: begin
                state_s = ST_IDLE;
                s_s     = '0;
                k_s     = '0;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so they can be registered.
    always_comb begin
        busy_s      = 1'b0;
        done_s      = 1'b0;
        stage_s     = s_s;
        rd_en_s     = 1'b0;
        rd_addr_a_s = o_rd_addr_a;
        rd_addr_b_s = o_rd_addr_b;
        tw_addr_s   = o_tw_addr;
        case (state_s)
            ST_IDLE: begin
                stage_s = '0;
            end
            ST_RUN: begin
                busy_s      = 1'b1;
                rd_en_s     = 1'b1;
                rd_addr_a_s = addr_a_f(s_s, k_s);
                rd_addr_b_s = addr_b_f(s_s, k_s);
                tw_addr_s   = tw_addr_f(s_s, k_s);
            end
            ST_DRAIN: begin
                busy_s = 1'b1;
            end
            ST_DONE: begin
                done_s  = 1'b1;
                stage_s = '0;
            end
            default: begin
                stage_s = '0;
            end
        endcase
    end

    // Registered control and read-side outputs; addresses hold while the strobe is low.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_stage     <= '0;
            o_rd_en     <= 1'b0;
            o_rd_addr_a <= '0;
            o_rd_addr_b <= '0;
            o_tw_addr   <= '0;
        end else begin
            o_busy      <= busy_s;
            o_done      <= done_s;
            o_stage     <= stage_s;
            o_rd_en     <= rd_en_s;
            o_rd_addr_a <= rd_addr_a_s;
            o_rd_addr_b <= rd_addr_b_s;
            o_tw_addr   <= tw_addr_s;
        end
    end

    // Write-back is the read request delayed by one cycle; reset squashes an in-flight read.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_wr_en     <= 1'b0;
            o_wr_addr_a <= '0;
            o_wr_addr_b <= '0;
        end else if (o_rd_en) begin
            o_wr_en     <= 1'b1;
            o_wr_addr_a <= o_rd_addr_a;
            o_wr_addr_b <= o_rd_addr_b;
        end else begin
            o_wr_en     <= 1'b0;
            o_wr_addr_a <= o_wr_addr_a;
            o_wr_addr_b <= o_wr_addr_b;
        end
    end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed testbench for fft_stage_sequencer (N = 8). A RAM/ROM/butterfly
// model runs in the loop so the final memory can be compared with a direct DFT.
module tb_fft_stage_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       done;
    logic [2:0] stage;
    logic       rd_en;
    logic [2:0] rd_a;
    logic [2:0] rd_b;
    logic [1:0] tw;
    logic       wr_en;
    logic [2:0] wr_a;
    logic [2:0] wr_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Hand-derived read schedule for N = 8, all three stages.
    int exp_a[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int exp_b[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int exp_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    // Twiddle ROM, W8^m scaled by 2^14.
    longint tw_re_rom[4] = '{64'sd16384, 64'sd11585, 64'sd0, -64'sd11585};
    longint tw_im_rom[4] = '{64'sd0, -64'sd11585, -64'sd16384, -64'sd11585};

    longint mem_re[8];
    longint mem_im[8];
    longint ra_re, ra_im, rb_re, rb_im, w_re, w_im;

    fft_stage_sequencer #(.N_LOG2(3)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .o_busy(busy), .o_done(done), .o_stage(stage),
        .o_rd_en(rd_en), .o_rd_addr_a(rd_a), .o_rd_addr_b(rd_b), .o_tw_addr(tw),
        .o_wr_en(wr_en), .o_wr_addr_a(wr_a), .o_wr_addr_b(wr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample RAM and twiddle ROM with 1-cycle read latency, plus a combinational butterfly on the write side.
    always @(posedge clk) begin
        longint tr, ti;
        tr = (rb_re * w_re - rb_im * w_im) >>> 14;
        ti = (rb_re * w_im + rb_im * w_re) >>> 14;
        if (wr_en) begin
            mem_re[wr_a] <= ra_re + tr;
            mem_im[wr_a] <= ra_im + ti;
            mem_re[wr_b] <= ra_re - tr;
            mem_im[wr_b] <= ra_im - ti;
        end
        if (rd_en) begin
            ra_re <= mem_re[rd_a];
            ra_im <= mem_im[rd_a];
            rb_re <= mem_re[rd_b];
            rb_im <= mem_im[rd_b];
            w_re  <= tw_re_rom[tw];
            w_im  <= tw_im_rom[tw];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        tick();
        tick();
        n_tests++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %0d want 0", busy); end
        n_tests++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done got %0d want 0", done); end
        n_tests++; if (stage !== 3'd0) begin n_fail++; $display("FAIL reset_stage got %0d want 0", stage); end
        n_tests++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got %0d want 0", rd_en); end
        n_tests++; if (rd_a !== 3'd0 || rd_b !== 3'd0 || tw !== 2'd0)
            begin n_fail++; $display("FAIL reset_rd_addr got %0d/%0d/%0d want 0/0/0", rd_a, rd_b, tw); end
        n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got %0d want 0", wr_en); end
        n_tests++; if (wr_a !== 3'd0 || wr_b !== 3'd0)
            begin n_fail++; $display("FAIL reset_wr_addr got %0d/%0d want 0/0", wr_a, wr_b); end
        rst_n = 1'b1;
        tick();
        n_tests++; if (busy !== 1'b0 || rd_en !== 1'b0)
            begin n_fail++; $display("FAIL idle_after_reset busy=%0d rd_en=%0d want 0/0", busy, rd_en); end
    endtask

    // Full N=8 schedule, write alignment, timing, and a dropped mid-run start.
    task automatic test_schedule;
        int n_wr   = 0;
        int n_busy = 0;
        int n_done = 0;
        int done_c = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            int  st, sl, idx, pidx, hidx;
            bit  e_rd, e_wr, e_busy, e_done;
            int  e_stage;
            st      = (c - 1) / 5;
            sl      = (c - 1) % 5;
            idx     = st * 4 + sl;
            e_rd    = (c <= 15) && (sl < 4);
            e_wr    = (c >= 2) && (c - 1 <= 15) && (((c - 2) % 5) < 4);
            pidx    = ((c - 2) / 5) * 4 + ((c - 2) % 5);
            hidx    = (c >= 16) ? 11 : st * 4 + 3;
            e_busy  = (c <= 15);
            e_done  = (c == 16);
            e_stage = (c <= 15) ? st : 0;
            n_tests++; if (rd_en !== e_rd)
                begin n_fail++; $display("FAIL sched_rd_en c=%0d got %0d want %0d", c, rd_en, e_rd); end
            if (e_rd) begin
                n_tests++; if (rd_a !== 3'(exp_a[idx]) || rd_b !== 3'(exp_b[idx]) || tw !== 2'(exp_tw[idx]))
                    begin n_fail++; $display("FAIL sched_rd_addr c=%0d got %0d,%0d,%0d want %0d,%0d,%0d",
                                             c, rd_a, rd_b, tw, exp_a[idx], exp_b[idx], exp_tw[idx]); end
            end else begin
                n_tests++; if (rd_a !== 3'(exp_a[hidx]) || rd_b !== 3'(exp_b[hidx]) || tw !== 2'(exp_tw[hidx]))
                    begin n_fail++; $display("FAIL sched_rd_hold c=%0d got %0d,%0d,%0d want %0d,%0d,%0d",
                                             c, rd_a, rd_b, tw, exp_a[hidx], exp_b[hidx], exp_tw[hidx]); end
            end
            n_tests++; if (wr_en !== e_wr)
                begin n_fail++; $display("FAIL sched_wr_en c=%0d got %0d want %0d", c, wr_en, e_wr); end
            if (e_wr) begin
                n_tests++; if (wr_a !== 3'(exp_a[pidx]) || wr_b !== 3'(exp_b[pidx]))
                    begin n_fail++; $display("FAIL sched_wr_addr c=%0d got %0d,%0d want %0d,%0d",
                                             c, wr_a, wr_b, exp_a[pidx], exp_b[pidx]); end
            end
            n_tests++; if (busy !== e_busy)
                begin n_fail++; $display("FAIL sched_busy c=%0d got %0d want %0d", c, busy, e_busy); end
            n_tests++; if (done !== e_done)
                begin n_fail++; $display("FAIL sched_done c=%0d got %0d want %0d", c, done, e_done); end
            n_tests++; if (stage !== 3'(e_stage))
                begin n_fail++; $display("FAIL sched_stage c=%0d got %0d want %0d", c, stage, e_stage); end
            if (rd_en === 1'b1 && wr_en === 1'b1) begin
                n_tests++; if (rd_a == wr_a || rd_a == wr_b || rd_b == wr_a || rd_b == wr_b)
                    begin n_fail++; $display("FAIL sched_collision c=%0d rd=%0d,%0d wr=%0d,%0d", c, rd_a, rd_b, wr_a, wr_b); end
            end
            if (wr_en === 1'b1) n_wr++;
            if (busy === 1'b1) n_busy++;
            if (done === 1'b1) begin n_done++; done_c = c; end
            start = (c == 7) ? 1'b1 : 1'b0;
            tick();
        end
        start = 1'b0;
        n_tests++; if (n_wr != 12)   begin n_fail++; $display("FAIL write_count got %0d want 12", n_wr); end
        n_tests++; if (n_busy != 15) begin n_fail++; $display("FAIL busy_cycles got %0d want 15", n_busy); end
        n_tests++; if (n_done != 1 || done_c != 16)
            begin n_fail++; $display("FAIL done_timing got %0d pulses at %0d want 1 at 16", n_done, done_c); end
    endtask

    // Full transform with the memory model; compare against a direct 8-point DFT.
    task automatic test_golden;
        longint xin[8] = '{64'sd64, 64'sd128, 64'sd192, 64'sd256, 64'sd0, 64'sd0, 64'sd0, 64'sd0};
        int     brev[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        bit     seen;
        real    pi, ref_re, ref_im, d_re, d_im;
        pi = 3.14159265358979;
        for (int i = 0; i < 8; i++) begin
            mem_re[i] = xin[brev[i]];
            mem_im[i] = 64'sd0;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done === 1'b1) seen = 1'b1;
            else tick();
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL golden_timeout got no done want done within 40"); end
        tick();
        n_tests++; if (mem_re[0] != 64'sd640 || mem_im[0] != 64'sd0)
            begin n_fail++; $display("FAIL golden_x0 got %0d,%0d want 640,0", mem_re[0], mem_im[0]); end
        n_tests++; if (mem_re[4] != -64'sd128 || mem_im[4] != 64'sd0)
            begin n_fail++; $display("FAIL golden_x4 got %0d,%0d want -128,0", mem_re[4], mem_im[4]); end
        for (int k = 0; k < 8; k++) begin
            ref_re = 0.0;
            ref_im = 0.0;
            for (int n = 0; n < 8; n++) begin
                ref_re = ref_re + $itor(xin[n]) * $cos(2.0 * pi * k * n / 8.0);
                ref_im = ref_im - $itor(xin[n]) * $sin(2.0 * pi * k * n / 8.0);
            end
            d_re = $itor(mem_re[k]) - ref_re;
            d_im = $itor(mem_im[k]) - ref_im;
            n_tests++; if (d_re > 4.0 || d_re < -4.0 || d_im > 4.0 || d_im < -4.0)
                begin n_fail++; $display("FAIL golden_bin k=%0d got %0d,%0d want %0d,%0d", k,
                                         mem_re[k], mem_im[k], $rtoi(ref_re), $rtoi(ref_im)); end
        end
    endtask

    // A start during DONE is dropped; a start in the following IDLE cycle is accepted.
    task automatic test_back_to_back;
        bit seen;
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done === 1'b1) seen = 1'b1;
            else tick();
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL b2b_timeout got no done want done within 40"); end
        start = 1'b1;
        tick();
        n_tests++; if (busy !== 1'b0 || rd_en !== 1'b0)
            begin n_fail++; $display("FAIL b2b_start_in_done busy=%0d rd_en=%0d want 0/0", busy, rd_en); end
        tick();
        start = 1'b0;
        n_tests++; if (busy !== 1'b1 || rd_en !== 1'b1 || rd_a !== 3'd0 || rd_b !== 3'd1)
            begin n_fail++; $display("FAIL b2b_restart busy=%0d rd_en=%0d a=%0d b=%0d want 1/1/0/1", busy, rd_en, rd_a, rd_b); end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done === 1'b1) seen = 1'b1;
            else tick();
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL b2b_second_done got no done want done within 40"); end
        tick();
    endtask

    // Reset in stage 1, k = 2 aborts; reset beats a coincident start; a fresh start restarts cleanly.
    task automatic test_reset_mid_run;
        bit seen;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        n_tests++; if (stage !== 3'd1 || rd_a !== 3'd4 || rd_b !== 3'd6 || tw !== 2'd0)
            begin n_fail++; $display("FAIL midrun_pos stage=%0d a=%0d b=%0d tw=%0d want 1/4/6/0", stage, rd_a, rd_b, tw); end
        rst_n = 1'b0;
        tick();
        n_tests++; if ({busy, done, stage, rd_en, rd_a, rd_b, tw, wr_en, wr_a, wr_b} !== 19'd0)
            begin n_fail++; $display("FAIL midrun_reset_outputs got %0h want 0",
                                     {busy, done, stage, rd_en, rd_a, rd_b, tw, wr_en, wr_a, wr_b}); end
        rst_n = 1'b1;
        tick();
        n_tests++; if (wr_en !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0)
            begin n_fail++; $display("FAIL midrun_after_reset wr=%0d rd=%0d busy=%0d want 0/0/0", wr_en, rd_en, busy); end
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_wins_start got %0d want 0", busy); end
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_not_queued got %0d want 0", busy); end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++; if (rd_en !== 1'b1 || rd_a !== 3'd0 || rd_b !== 3'd1 || tw !== 2'd0 || stage !== 3'd0)
            begin n_fail++; $display("FAIL fresh_start rd=%0d a=%0d b=%0d tw=%0d s=%0d want 1/0/1/0/0",
                                     rd_en, rd_a, rd_b, tw, stage); end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done === 1'b1) seen = 1'b1;
            else tick();
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL fresh_done got no done want done within 40"); end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mem_re[i] = 64'sd0;
            mem_im[i] = 64'sd0;
        end
        test_reset();
        test_schedule();
        test_golden();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Sequences the combinational butterfly_sum datapath through an in-place radix-2 decimation-in-time FFT of N = 2^N_LOG2 complex words. Input data is already stored bit-reversed in a dual-port sample RAM.
- Each cycle it issues one butterfly's pair of read addresses and its twiddle ROM address.
- One cycle later it issues the matching write-back strobe and addresses, so butterfly_sum's o_A/o_B return to the same locations.
- Sits between the top-level FFT control (start/done) and the sample RAM / twiddle ROM feeding butterfly_sum.

Parameters:
- N_LOG2, default 3, log2 of FFT length N (N = 8 by default); legal range 1..10.
- ADDR_W, default N_LOG2, sample RAM address width.
- TW_W, default N_LOG2-1 (minimum 1), twiddle ROM address width; the ROM holds N/2 entries.

Ports:
- i_clk, input, 1, system clock; all logic is rising-edge.
- i_rst_n, input, 1, synchronous active-low reset.
- i_start, input, 1, single-cycle request to begin a transform; ignored unless in IDLE.
- o_busy, output, 1, high from the cycle after an accepted start until DONE is reached.
- o_done, output, 1, single-cycle pulse when the transform completes.
- o_stage, output, N_LOG2 (min 1), current stage index s.
- o_rd_en, output, 1, read strobe for both RAM ports and the twiddle ROM.
- o_rd_addr_a, output, ADDR_W, RAM port A read address (butterfly top input).
- o_rd_addr_b, output, ADDR_W, RAM port B read address (butterfly bottom input).
- o_tw_addr, output, TW_W, twiddle ROM address.
- o_wr_en, output, 1, write strobe for both RAM ports (butterfly o_A and o_B).
- o_wr_addr_a, output, ADDR_W, write address for o_A.
- o_wr_addr_b, output, ADDR_W, write address for o_B.

Behaviour:
- Reset: synchronous on i_rst_n = 0. State goes to IDLE, counters s = 0 and k = 0, and every output goes to 0.
  - Reset mid-transform aborts immediately. No o_wr_en is issued in the cycle after reset, even if a read was in flight.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: when i_start = 1, go to RUN with s = 0, k = 0.
  - RUN: o_rd_en = 1 and one butterfly k is issued per cycle. k increments, and after k = N/2-1 go to DRAIN.
  - DRAIN: exactly one bubble cycle with o_rd_en = 0, in which the final write of the stage lands.
    - If s < N_LOG2-1: s increments, k = 0, return to RUN.
    - Otherwise go to DONE.
  - DONE: o_done = 1 for one cycle, then return to IDLE.
- Address generation in RUN, with half = 2^s, grp = k >> s, pos = k & (half-1):
  - rd_addr_a = grp*2*half + pos
  - rd_addr_b = rd_addr_a + half
  - tw_addr = pos << (N_LOG2-1-s)
  - All arithmetic is unsigned, with no wrap beyond N-1.
- Write path:
  - The RAM and ROM have 1-cycle read latency; butterfly_sum is combinational.
  - o_wr_en, o_wr_addr_a and o_wr_addr_b are o_rd_en, o_rd_addr_a and o_rd_addr_b registered by exactly one cycle.
  - In DONE and IDLE, o_wr_en is 0, except for the delayed copy of the last RUN read, which lands in DRAIN.
- The DRAIN bubble guarantees stage s+1 never reads a location in the same cycle stage s writes it. No read/write address collision ever occurs in the same cycle.
- o_busy is 1 in RUN and DRAIN, and 0 in IDLE and DONE.
- o_stage holds s; it returns to 0 in DONE.
- Total latency: from accepted i_start to the o_done cycle is N_LOG2*(N/2+1) + 1 cycles. For N = 8 this is 16.
- i_start asserted while busy or in DONE is dropped; it is not queued.
- i_start asserted in the same cycle as i_rst_n = 0: reset wins.
- o_rd_addr_*, o_tw_addr and o_wr_addr_* are don't-care-free: they hold their last value when the corresponding strobe is low.

Test Plan:
- Reset, then i_start pulse, N = 8 -> stage 0 reads (a,b,tw) = (0,1,0), (2,3,0), (4,5,0), (6,7,0) on consecutive cycles, then one cycle with o_rd_en = 0.
- Same run, stage 1 -> (0,2,0), (1,3,2), (4,6,0), (5,7,2); stage 2 -> (0,4,0), (1,5,1), (2,6,2), (3,7,3).
- Write alignment -> every o_wr_en cycle shows the previous cycle's read addresses. There are exactly 12 write strobes. No cycle has o_rd_en and o_wr_en targeting the same address.
- Timing -> o_done is high exactly 16 cycles after the i_start cycle, for one cycle. o_busy is high for 15 cycles. A second i_start asserted mid-run produces no extra transform.
- Reset mid-run (i_rst_n low in stage 1, k = 2) -> next cycle all outputs are 0 and no o_wr_en is seen. A fresh i_start then restarts at stage 0, k = 0.
- Golden check: bit-reversed samples 64,128,192,256 (Q-format, <<6), with memory and ROM models and butterfly_sum in the loop -> final RAM contents match a reference 8-point FFT, bit-exact for real twiddles.
